// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds the FSM state encoding, datapath widths and the address legality rule.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // An access is illegal when misaligned or when its word index falls past the array.
  function automatic logic addr_illegal(input logic [WORD_W-1:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write, combinational read.
// Contents are intentionally never reset so they survive a CPU reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory slave for an in-order pipeline: stalls the CPU for
// LATENCY cycles per access, then completes in a one-cycle DONE state.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] write_data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              is_write_q, is_write_d;
  logic              conflict_q, conflict_d;
  logic              illegal_q, illegal_d;

  logic              req;
  logic              in_done;
  logic              mem_we;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] load_val;

  assign req     = MemRead_i | MemWrite_i;
  assign in_done = rst_i && (state_q == DONE);

  // Illegal accesses never touch the array; a read-and-write collision still stores.
  assign mem_we   = in_done && is_write_q && !illegal_q;
  assign load_val = illegal_q ? '0 : rdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    is_write_d = is_write_q;
    conflict_d = conflict_q;
    illegal_d  = illegal_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d      = addr_i[AW+1:2];
          wdata_d    = write_data_i;
          is_write_d = MemWrite_i;
          conflict_d = MemRead_i && MemWrite_i;
          illegal_d  = addr_illegal(addr_i, DEPTH);
          cnt_d      = CNT_LOAD;
          state_d    = (LATENCY == 1) ? DONE : BUSY;
        end
      end

      BUSY: begin
        // Leave BUSY on the last stall cycle so the counter bottoms out at zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!is_write_q) begin
          data_d = load_val;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      conflict_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      is_write_q <= is_write_d;
      conflict_q <= conflict_d;
      illegal_q  <= illegal_d;
    end
  end

  // The accept cycle stalls combinationally; reset overrides it so a held request can't freeze the pipe.
  assign stall_o = rst_i && ((state_q == BUSY) || ((state_q == IDLE) && req));
  assign done_o  = in_done;
  assign err_o   = in_done && (illegal_q || conflict_q);
  assign data_o  = (in_done && !is_write_q) ? load_val : data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: one LATENCY=3 instance for the main scenarios
// and one LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_b = 1'b0;
  logic        rd_r = 1'b0;
  logic        wr_r = 1'b0;
  logic [31:0] addr_r = '0;
  logic [31:0] wdata_r = '0;

  logic [31:0] a_data, b_data;
  logic        a_stall, a_done, a_err;
  logic        b_stall, b_done, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(3), .DEPTH(256)) dut_a (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .addr_i       (addr_r),
    .write_data_i (wdata_r),
    .MemRead_i    (rd_r & ~sel_b),
    .MemWrite_i   (wr_r & ~sel_b),
    .data_o       (a_data),
    .stall_o      (a_stall),
    .done_o       (a_done),
    .err_o        (a_err)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(256)) dut_b (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .addr_i       (addr_r),
    .write_data_i (wdata_r),
    .MemRead_i    (rd_r & sel_b),
    .MemWrite_i   (wr_r & sel_b),
    .data_o       (b_data),
    .stall_o      (b_stall),
    .done_o       (b_done),
    .err_o        (b_err)
  );

  // Presents one request, holds it until done_o (bounded), then drops it; returns observations.
  task automatic do_access(input bit use_b, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int stall_cnt, output int lat, output bit seen,
                           output logic err_d, output logic [31:0] data_d);
    stall_cnt = 0;
    lat = 0;
    seen = 1'b0;
    err_d = 1'b0;
    data_d = '0;
    @(posedge clk); #1;
    sel_b = use_b;
    rd_r = rd;
    wr_r = wr;
    addr_r = addr;
    wdata_r = wdata;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (use_b ? b_stall : a_stall) stall_cnt++;
      if (use_b ? b_done : a_done) begin
        seen = 1'b1;
        lat = i;
        err_d = use_b ? b_err : a_err;
        data_d = use_b ? b_data : a_data;
      end
    end
    @(posedge clk); #1;
    rd_r = 1'b0;
    wr_r = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel_b = 1'b0;
    rd_r = 1'b1;
    addr_r = 32'd16;
    @(negedge clk);
    checks++;
    if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_override got %0b want 0", a_stall); end
    @(posedge clk); #1;
    rd_r = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_stall !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl got stall=%0b done=%0b err=%0b want 000", a_stall, a_done, a_err); end
    checks++;
    if (a_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", a_data); end
    checks++;
    if (dut_a.state_q !== IDLE || dut_a.cnt_q !== 4'd0)
      begin errors++; $display("FAIL reset_state got state=%0d cnt=%0d want 0 0", dut_a.state_q, dut_a.cnt_q); end
    checks++;
    if (b_stall !== 1'b0 || b_done !== 1'b0 || b_data !== 32'h0)
      begin errors++; $display("FAIL reset_b got stall=%0b done=%0b data=%h want 0 0 0", b_stall, b_done, b_data); end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_preload();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    logic [31:0] addrs [3];
    logic [31:0] vals [3];
    addrs[0] = 32'd16;   vals[0] = 32'hDEADBEEF;
    addrs[1] = 32'd0;    vals[1] = 32'h11111111;
    addrs[2] = 32'd1020; vals[2] = 32'h22222222;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b0, 1'b0, 1'b1, addrs[k], vals[k], sc, lat, seen, e, d);
      checks++;
      if (seen !== 1'b1 || e !== 1'b0 || sc != 3)
        begin errors++; $display("FAIL preload_store[%0d] got seen=%0b err=%0b stalls=%0d want 1 0 3", k, seen, e, sc); end
      $display("preload: store addr=%0d data=%h stalls=%0d", addrs[k], vals[k], sc);
    end
  endtask

  task automatic test_read_latency();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    do_access(1'b0, 1'b1, 1'b0, 32'd16, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || lat != 3) begin errors++; $display("FAIL read_latency got seen=%0b cycles=%0d want 1 3", seen, lat); end
    checks++;
    if (sc != 3) begin errors++; $display("FAIL read_stall_cycles got %0d want 3", sc); end
    checks++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL read_data got %h err=%0b want deadbeef 0", d, e); end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL read_hold got done=%0b data=%h want 0 deadbeef", a_done, a_data); end
    $display("read: addr=16 data=%h stalls=%0d latency=%0d", d, sc, lat);
  endtask

  task automatic test_store_then_load();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    do_access(1'b0, 1'b0, 1'b1, 32'd8, 32'h12345678, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || d !== 32'hDEADBEEF || e !== 1'b0)
      begin errors++; $display("FAIL store_data_hold got seen=%0b data=%h err=%0b want 1 deadbeef 0", seen, d, e); end
    checks++;
    if (dut_a.u_array.mem_q[2] !== 32'h12345678)
      begin errors++; $display("FAIL store_commit got %h want 12345678", dut_a.u_array.mem_q[2]); end
    $display("store: addr=8 data=12345678 data_o_at_done=%h", d);
    do_access(1'b0, 1'b1, 1'b0, 32'd8, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || d !== 32'h12345678)
      begin errors++; $display("FAIL store_readback got seen=%0b data=%h want 1 12345678", seen, d); end
    $display("load: addr=8 data=%h", d);
  endtask

  task automatic test_illegal();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    do_access(1'b0, 1'b1, 1'b0, 32'd6, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || e !== 1'b1 || d !== 32'h0)
      begin errors++; $display("FAIL misaligned_load got seen=%0b err=%0b data=%h want 1 1 00000000", seen, e, d); end
    $display("load: addr=6 err=%0b data=%h", e, d);
    do_access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || e !== 1'b1 || d !== 32'h0)
      begin errors++; $display("FAIL range_store got seen=%0b err=%0b data=%h want 1 1 00000000", seen, e, d); end
    $display("store: addr=1024 err=%0b", e);
    do_access(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (d !== 32'h11111111 || e !== 1'b0)
      begin errors++; $display("FAIL word0_intact got %h err=%0b want 11111111 0", d, e); end
    $display("load: addr=0 data=%h", d);
    do_access(1'b0, 1'b1, 1'b0, 32'd1020, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (d !== 32'h22222222 || e !== 1'b0)
      begin errors++; $display("FAIL word255_intact got %h err=%0b want 22222222 0", d, e); end
    $display("load: addr=1020 data=%h", d);
  endtask

  task automatic test_conflict();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    do_access(1'b0, 1'b1, 1'b1, 32'd12, 32'hA5A5A5A5, sc, lat, seen, e, d);
    checks++;
    if (seen !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL conflict_err got seen=%0b err=%0b want 1 1", seen, e); end
    checks++;
    if (dut_a.u_array.mem_q[3] !== 32'hA5A5A5A5)
      begin errors++; $display("FAIL conflict_store got %h want a5a5a5a5", dut_a.u_array.mem_q[3]); end
    $display("rd+wr: addr=12 err=%0b word3=%h", e, dut_a.u_array.mem_q[3]);
  endtask

  task automatic test_reset_abort();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    bit done_seen;
    @(posedge clk); #1;
    sel_b = 1'b0;
    wr_r = 1'b1;
    addr_r = 32'd0;
    wdata_r = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_r = 1'b0;
    @(negedge clk);
    checks++;
    if (a_stall !== 1'b0) begin errors++; $display("FAIL abort_stall_override got %0b want 0", a_stall); end
    @(posedge clk); #1;
    checks++;
    if (dut_a.state_q !== IDLE || a_stall !== 1'b0)
      begin errors++; $display("FAIL abort_idle got state=%0d stall=%0b want 0 0", dut_a.state_q, a_stall); end
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got done pulse want none"); end
    do_access(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, sc, lat, seen, e, d);
    checks++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL abort_no_store got %h want 11111111", d); end
    $display("abort: store to addr 0 aborted, word0=%h", d);
  endtask

  task automatic test_back_to_back();
    int sc, lat; bit seen; logic e; logic [31:0] d;
    int acc;
    int stall_total;
    logic [31:0] exp_vals [4];
    exp_vals[0] = 32'hB0B0B0B0;
    exp_vals[1] = 32'hB1B1B1B1;
    exp_vals[2] = 32'hB2B2B2B2;
    exp_vals[3] = 32'hB3B3B3B3;
    for (int k = 0; k < 4; k++) begin
      do_access(1'b1, 1'b0, 1'b1, 32'(k * 4), exp_vals[k], sc, lat, seen, e, d);
      checks++;
      if (seen !== 1'b1 || sc != 1 || lat != 1)
        begin errors++; $display("FAIL lat1_store[%0d] got seen=%0b stalls=%0d cycles=%0d want 1 1 1", k, seen, sc, lat); end
    end
    acc = 0;
    stall_total = 0;
    @(posedge clk); #1;
    sel_b = 1'b1;
    rd_r = 1'b1;
    addr_r = 32'd0;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      @(negedge clk);
      if (b_stall) begin
        stall_total++;
        checks++;
        if (cyc != 2 * acc) begin errors++; $display("FAIL b2b_accept[%0d] got cycle %0d want %0d", acc, cyc, 2 * acc); end
      end
      if (b_done) begin
        checks++;
        if (cyc != 2 * acc + 1 || b_data !== exp_vals[acc])
          begin errors++; $display("FAIL b2b_done[%0d] got cycle=%0d data=%h want %0d %h", acc, cyc, b_data, 2 * acc + 1, exp_vals[acc]); end
        $display("b2b: load %0d done at cycle %0d data=%h", acc, cyc, b_data);
        acc++;
        @(posedge clk); #1;
        if (acc < 4) addr_r = 32'(acc * 4);
        else rd_r = 1'b0;
      end
    end
    rd_r = 1'b0;
    checks++;
    if (acc != 4 || stall_total != 4)
      begin errors++; $display("FAIL b2b_total got accesses=%0d stalls=%0d want 4 4", acc, stall_total); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_latency();
    test_store_then_load();
    test_illegal();
    test_conflict();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 3, meaning cycles stall_o is held per access (legal range 1..15).
REQ-002 Parameter DEPTH, default 256, meaning number of 32-bit words of storage.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-low.
REQ-005 addr_i  input  32  byte address from the CPU's EX/MEM ALU result.
REQ-006 write_data_i  input  32  store data.
REQ-007 MemRead_i  input  1  load request.
REQ-008 MemWrite_i  input  1  store request.
REQ-009 data_o  output  32  load data to the MEM/WB stage.
REQ-010 stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-011 done_o  output  1  one-cycle pulse at access completion.
REQ-012 err_o  output  1  one-cycle pulse with done_o for an illegal access.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: no access in progress.
- BUSY: access in progress; latency count running.
- DONE: completion cycle.
REQ-014 In IDLE, MemRead_i or MemWrite_i high at cycle T SHALL capture addr, data and op, with stall_o asserted combinationally in cycle T.
REQ-015 stall_o SHALL be high for exactly LATENCY consecutive cycles, T..T+LATENCY-1, and the FSM SHALL be in DONE at cycle T+LATENCY.
REQ-016 With LATENCY=1, the FSM SHALL go IDLE to DONE directly, with no BUSY cycle.
REQ-017 In DONE:
- stall_o=0 and done_o=1.
- A store SHALL be committed to the array at the end of DONE.
- Load data SHALL be on data_o during DONE.
REQ-018 DONE SHALL ignore request inputs, because the CPU still presents the completed request that cycle; the next state SHALL be IDLE.
REQ-019 Request inputs SHALL be ignored in BUSY; only the captured values are used.
REQ-020 data_o SHALL hold the last completed load's value until the next load completes; stores SHALL leave data_o unchanged.
REQ-021 If MemRead_i and MemWrite_i are both high, the access SHALL be treated as a store and err_o SHALL pulse in DONE.
REQ-022 If addr[1:0]!=0 or the word index addr[31:2]>=DEPTH, then in DONE:
- no store SHALL be committed;
- a load SHALL return 32'h0;
- err_o SHALL pulse.
REQ-023 Back-to-back requests SHALL be accepted in the IDLE cycle immediately after DONE, giving a minimum spacing of LATENCY+1 cycles per access.
REQ-024 The latency counter SHALL be 4 bits and SHALL never wrap; it loads at accept and decrements in BUSY only.

Reset
REQ-025 When rst_i is low at a clock edge, the block SHALL enter IDLE with:
- data_o=0, done_o=0, err_o=0;
- stall_o=0, overriding the combinational request term while rst_i is low;
- counter=0.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the access, with no store committed.
REQ-027 Storage contents SHALL NOT be reset; they are preloadable by the testbench.

Structure
REQ-028 A shared package SHALL hold:
- the state enum (IDLE, BUSY, DONE);
- the word-width constant 32;
- the counter-width constant 4.
REQ-029 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read, DEPTH words); the FSM, counter and legality checks SHALL stay in data_mem_responder.

Verification
REQ-030 Preload word 4 = 32'hDEADBEEF; issue MemRead with addr 16 at cycle T, LATENCY=3 -> stall_o high T..T+2, done_o and data_o=32'hDEADBEEF at T+3.
REQ-031 MemWrite addr 8, data 32'h12345678, then MemRead addr 8 -> read returns 32'h12345678; data_o unchanged during the store's DONE.
REQ-032 MemRead addr 6 (misaligned), then MemWrite addr 1024 (out of range, DEPTH=256) -> each gives err_o=1 with done_o; the load returns 0; word 0 and word 255 are unchanged.
REQ-033 Assert rst_i low at T+1 of a store to addr 0 -> stall_o=0 and FSM in IDLE the next cycle; word 0 keeps its old value; no done_o pulse.
REQ-034 LATENCY=1, four consecutive loads, each held by the CPU model until done_o -> stall_o high for exactly 1 cycle per access; accepts at T, T+2, T+4, T+6.
REQ-035 MemRead and MemWrite both high, addr 12, data 32'hA5A5A5A5 -> word 3 = 32'hA5A5A5A5 and err_o pulses.
